pattern_serial_tx: RTL and testbench



---
 rtl/pattern_tx_pkg.sv | 17 +
 rtl/pattern_shreg.sv | 30 +++
 rtl/pattern_serial_tx.sv | 146 ++++++++++++++
 tb/tb_pattern_serial_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
// Optional feature macro: PATTERN_SERIAL_TX_PARITY_EN (even-parity bit per frame).
package pattern_tx_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } tx_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 2;
    localparam int DEF_CNTW  = 4;

endpackage

// File: rtl/pattern_shreg.sv
// Loadable left-shift register; exposes its MSB as the serial bit.
module pattern_shreg
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    // Load has priority over shift; zeros enter at the LSB end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first on w,
// repeated repeat_count times with GAP idle cycles between frames.
// Moore outputs decoded from registered state only.
// Optional feature macro: PATTERN_SERIAL_TX_PARITY_EN appends an even-parity bit.
module pattern_serial_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNTW-1:0]  repeat_count,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

`ifdef PATTERN_SERIAL_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

    tx_state_t        state, state_d;
    logic [BW-1:0]    bit_cnt, bit_cnt_d;
    logic [CNTW-1:0]  reps_left, reps_left_d;
    logic [GW-1:0]    gap_cnt, gap_cnt_d;
    logic [WIDTH-1:0] pat_q, pat_d;

    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_din;
    logic             sh_msb;
    logic             tx_bit;

    pattern_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk  (Clock),
        .rst_n(Resetn),
        .load (sh_load),
        .shift(sh_shift),
        .din  (sh_din),
        .msb  (sh_msb)
    );

    // State and counter registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            pat_q     <= '0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            reps_left <= reps_left_d;
            gap_cnt   <= gap_cnt_d;
            pat_q     <= pat_d;
        end
    end

    // Next-state, counter updates and shift-register control
    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        reps_left_d = reps_left;
        gap_cnt_d   = gap_cnt;
        pat_d       = pat_q;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_din      = pat_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    pat_d       = pattern;
                    sh_din      = pattern;
                    sh_load     = 1'b1;
                    reps_left_d = (repeat_count == '0) ? CNTW'(1) : repeat_count;
                    bit_cnt_d   = '0;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_shift  = 1'b1;
                bit_cnt_d = bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (reps_left > CNTW'(1)) begin
                        reps_left_d = reps_left - 1'b1;
                        // Reload on leaving the frame rather than at the end of
                        // the gap: w is masked during GAP, so the stream is the same
                        sh_load = 1'b1;
                        if (GAP == 0) begin
                            state_d = S_SHIFT;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt + 1'b1;
                if (gap_cnt == LAST_GAP) begin
                    gap_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode from registered state
    always_comb begin
`ifdef PATTERN_SERIAL_TX_PARITY_EN
        tx_bit = (bit_cnt == BW'(WIDTH)) ? ^pat_q : sh_msb;
`else
        tx_bit = sh_msb;
`endif
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        w_valid = (state == S_SHIFT);
        w       = w_valid & tx_bit;
    end

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Self-checking bench for pattern_serial_tx with a frame-level stream model.
// Optional feature macro: PATTERN_SERIAL_TX_PARITY_EN (must match the RTL build).
module tb_pattern_serial_tx;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
    localparam int CNTW  = 4;
`ifdef PATTERN_SERIAL_TX_PARITY_EN
    localparam int F = WIDTH + 1;
    localparam logic [F-1:0] EXP_D3 = 9'b1101_0011_1;
    localparam logic [F-1:0] EXP_07 = 9'b0000_0111_1;
    localparam int DONE_R1 = 10;
    localparam int DONE_R3 = 32;
`else
    localparam int F = WIDTH;
    localparam logic [F-1:0] EXP_D3 = 8'b1101_0011;
    localparam logic [F-1:0] EXP_07 = 8'b0000_0111;
    localparam int DONE_R1 = 9;
    localparam int DONE_R3 = 29;
`endif

    logic             Clock = 1'b0;
    logic             Resetn = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [CNTW-1:0]  repeat_count = '0;
    logic             w, w_valid, busy, done;

    int checks = 0;
    int errors = 0;

    pattern_serial_tx #(
        .WIDTH(WIDTH),
        .GAP  (GAP),
        .CNTW (CNTW)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .start       (start),
        .pattern     (pattern),
        .repeat_count(repeat_count),
        .w           (w),
        .w_valid     (w_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 Clock = ~Clock;

    // Expected per-cycle {w, w_valid, busy, done}; empty queue means idle
    logic [3:0] exp_q[$];
    logic       cur_busy = 1'b0;

    function automatic void build_stream(input logic [WIDTH-1:0] p, input logic [CNTW-1:0] rc);
        int unsigned r;
        r = (rc == 0) ? 1 : int'(rc);
        for (int unsigned f = 0; f < r; f++) begin
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
`ifdef PATTERN_SERIAL_TX_PARITY_EN
            exp_q.push_back({^p, 3'b110});
`endif
            if (f != r - 1)
                for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0011);
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Model: accept a start only at an edge closing an idle cycle
    always @(posedge Clock) begin
        if (Resetn && !cur_busy && start && exp_q.size() == 0)
            build_stream(pattern, repeat_count);
    end

    always @(negedge Resetn) begin
        exp_q.delete();
        cur_busy = 1'b0;
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge Clock) begin
        logic [3:0] e;
        logic [3:0] a;
        e = 4'b0000;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        cur_busy = e[1];
        a = {w, w_valid, busy, done};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL stream: got w/v/b/d=%b expected %b (t=%0t)", a, e, $time);
        end
    end

    // Issue a start; returns during cycle 1 (after the accept edge)
    task automatic send(input logic [WIDTH-1:0] p, input logic [CNTW-1:0] rc);
        @(posedge Clock); #2;
        start = 1'b1; pattern = p; repeat_count = rc;
        @(posedge Clock); #2;
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [WIDTH-1:0] p, input logic [CNTW-1:0] rc,
                             input bit disturb, output int done_at,
                             output logic [F-1:0] bits, output int busy_cycles);
        send(p, rc);
        done_at = -1;
        bits = '0;
        busy_cycles = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge Clock);
            if (c <= F) bits = {bits[F-2:0], w};
            if (busy) busy_cycles++;
            if (disturb && c == 3) begin start = 1'b1; pattern = '1; repeat_count = 4'd5; end
            if (disturb && c == 4) start = 1'b0;
            if (done) begin done_at = c; break; end
        end
        if (done_at < 0) $display("FAIL timeout: no done within 200 cycles (t=%0t)", $time);
    endtask

    initial begin
        int d, bc, r;
        logic [F-1:0] b;
        logic [WIDTH-1:0] rp;
        logic [CNTW-1:0] rr;

        #1 Resetn = 1'b0;
        #20;
        check("reset_outputs", int'({w, w_valid, busy, done}), 0);
        @(posedge Clock); #2 Resetn = 1'b1;

        // Single frame
        run_frame(8'b1101_0011, 4'd1, 1'b0, d, b, bc);
        check("r1_bits", int'(b), int'(EXP_D3));
        check("r1_done_cycle", d, DONE_R1);
        check("r1_busy_cycles", bc, DONE_R1);

        // Three frames with gaps
        run_frame(8'b1101_0011, 4'd3, 1'b0, d, b, bc);
        check("r3_done_cycle", d, DONE_R3);

        // repeat_count 0 behaves as 1
        run_frame(8'b1101_0011, 4'd0, 1'b0, d, b, bc);
        check("r0_bits", int'(b), int'(EXP_D3));
        check("r0_done_cycle", d, DONE_R1);

        // start and pattern changes while busy are ignored
        run_frame(8'b1101_0011, 4'd1, 1'b1, d, b, bc);
        check("ignore_bits", int'(b), int'(EXP_D3));
        check("ignore_done_cycle", d, DONE_R1);
        repeat (3) @(negedge Clock);
        check("ignore_no_second_frame", int'(busy), 0);
        start = 1'b0;

        // Asynchronous reset during bit 4
        send(8'b1101_0011, 4'd2);
        repeat (3) @(negedge Clock);
        @(posedge Clock); #3;
        check("pre_reset_busy", int'(busy), 1);
        Resetn = 1'b0;
        #1;
        check("async_reset_outputs", int'({w, w_valid, busy, done}), 0);
        @(posedge Clock); #2 Resetn = 1'b1;
        run_frame(8'b1101_0011, 4'd1, 1'b0, d, b, bc);
        check("post_reset_bits", int'(b), int'(EXP_D3));
        check("post_reset_done_cycle", d, DONE_R1);

        // Small pattern (parity bit is 1 when enabled)
        run_frame(8'h07, 4'd1, 1'b0, d, b, bc);
        check("p07_bits", int'(b), int'(EXP_07));
        check("p07_done_cycle", d, DONE_R1);

        // Randomized frames with random idle spacing
        for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge Clock);
            rp = WIDTH'($urandom);
            rr = CNTW'($urandom_range(0, 3));
            r = (rr == 0) ? 1 : int'(rr);
            run_frame(rp, rr, 1'b0, d, b, bc);
            check("rand_done_cycle", d, r * F + (r - 1) * GAP + 1);
        end

        // start held high: back-to-back accepts one cycle after done
        @(posedge Clock); #2 start = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge Clock); #2;
            pattern = WIDTH'($urandom);
            repeat_count = CNTW'($urandom_range(0, 2));
        end
        start = 1'b0;
        repeat (60) @(posedge Clock);
        check("final_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
